// File: rtl/fifo_pkg.sv
// fifo_pkg: shared driver state/pattern enums and Galois LFSR tap masks
package fifo_pkg;
  typedef enum logic [2:0] {IDLE, FRST, BURST, GAP, DONE} drv_state_e;
  typedef enum logic [1:0] {INCR, LFSR, WALK, CONST} pattern_e;
  function automatic logic [31:0] lfsr_taps(input int width);
    return width == 8 ? 32'h0000_00B8 : width == 16 ? 32'h0000_B400 :
           width == 32 ? 32'h8020_0003 : 32'h0;
  endfunction
endpackage

// File: rtl/fifo_pattern_gen.sv
// fifo_pattern_gen: data_in register advancing as incr, Galois LFSR, walking-one or constant
module fifo_pattern_gen
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_wr,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
  pattern_e mode_q, mode_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, load_val, next_val;
  always_comb begin
    load_val = pattern_e'(mode_i) == WALK || (pattern_e'(mode_i) == LFSR && seed_i == '0)
             ? DATA_WIDTH'(1) : seed_i;
    next_val = mode_q == INCR ? data_q + 1'b1
             : mode_q == LFSR ? (data_q >> 1) ^ (data_q[0] ? TAPS : '0)
             : mode_q == WALK ? {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]}
             : data_q;
    mode_d   = load_i ? pattern_e'(mode_i) : mode_q;
    data_d   = load_i ? load_val : advance_i ? next_val : data_q;
  end
  always_ff @(posedge clk_wr) begin
    if (rst) begin
      mode_q <= INCR;
      data_q <= '0;
    end else begin
      mode_q <= mode_d;
      data_q <= data_d;
    end
  end
  assign data_o = data_q;
endmodule

// File: rtl/fifo_wr_burst_gen.sv
// fifo_wr_burst_gen: FIFO write-port traffic generator (optional reset pulse, N bursts of M words)
// Optional FIFO_HALF_THROTTLE_EN: halves the write rate while half is asserted.
module fifo_wr_burst_gen
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                  clk_wr,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  init_fifo,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic [LEN_W-1:0]      gap_len,
  input  logic [LEN_W-1:0]      num_bursts,
  input  logic                  abort,
  input  logic                  full,
  input  logic                  half,
  output logic                  fifo_rst_n,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           words_sent
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int CW = LEN_W > RW ? LEN_W : RW;
  drv_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] word_q, word_d, bcnt_q, bcnt_d, blen_q, blen_d, gap_q, gap_d, nb_q, nb_d;
  logic [15:0] words_q, words_d;
  logic thr_q, thr_d, thr_ok, last_word, last_burst, load;
`ifndef FIFO_HALF_THROTTLE_EN
  logic unused_half;
  assign unused_half = half;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    bcnt_d     = bcnt_q;
    blen_d     = blen_q;
    gap_d      = gap_q;
    nb_d       = nb_q;
    words_d    = words_q;
`ifdef FIFO_HALF_THROTTLE_EN
    thr_ok     = half ? thr_q : 1'b1;
`else
    thr_ok     = thr_q;
`endif
    wr_en      = state_q == BURST && !full && thr_ok && !abort;
    last_word  = word_q == blen_q - 1'b1;
    last_burst = bcnt_q == nb_q - 1'b1;
    load       = state_q == IDLE && start && !abort;
    case (state_q)
      IDLE: if (load) begin
        state_d = init_fifo ? FRST : BURST;
        cnt_d   = '0;
        word_d  = '0;
        bcnt_d  = '0;
        blen_d  = burst_len == '0 ? LEN_W'(1) : burst_len;
        gap_d   = gap_len;
        nb_d    = num_bursts == '0 ? LEN_W'(1) : num_bursts;
        words_d = '0;
      end
      FRST: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(RST_CYCLES - 1) ? BURST : FRST;
      end
      BURST: if (wr_en) begin
        words_d = &words_q ? words_q : words_q + 1'b1;
        word_d  = last_word ? '0 : word_q + 1'b1;
        if (last_word) begin
          bcnt_d  = bcnt_q + 1'b1;
          cnt_d   = '0;
          state_d = last_burst ? DONE : gap_q == '0 ? BURST : GAP;
        end
      end
      GAP: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(gap_q) - 1'b1 ? BURST : GAP;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    // toggle phase restarts at 1 whenever a burst begins
`ifdef FIFO_HALF_THROTTLE_EN
    thr_d = state_q != BURST || (wr_en && last_word) ? 1'b1 : half ? ~thr_q : 1'b1;
`else
    thr_d = 1'b1;
`endif
  end
  always_ff @(posedge clk_wr) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      blen_q  <= LEN_W'(1);
      gap_q   <= '0;
      nb_q    <= LEN_W'(1);
      words_q <= '0;
      thr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      blen_q  <= blen_d;
      gap_q   <= gap_d;
      nb_q    <= nb_d;
      words_q <= words_d;
      thr_q   <= thr_d;
    end
  end
  fifo_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pat (
    .clk_wr   (clk_wr),
    .rst      (rst),
    .load_i   (load),
    .advance_i(wr_en),
    .mode_i   (mode),
    .seed_i   (seed),
    .data_o   (data_in)
  );
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign fifo_rst_n = !(state_q == FRST && !abort);
  assign words_sent = words_q;
endmodule
